// File: rtl/addr_sequencer.sv
// Address sequencer: pops FWFT address words, optionally expands each into a
// run of consecutive addresses, and issues them over a valid/ready handshake.
module addr_sequencer #(
  parameter logic [31:0] END_MARKER  = 32'hFFFF_FFFF,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   active_program,
  input  logic                   send_consec_addr,
  input  logic [7:0]             consec_count,
  input  logic [31:0]            addr_fifo_dout,
  input  logic                   addr_fifo_empty,
  output logic                   addr_fifo_rd,
  output logic [31:0]            vctr_addr,
  output logic                   vctr_addr_valid,
  input  logic                   vctr_addr_ready,
  output logic                   prog_done,
  output logic                   addr_fifo_underrun,
  output logic [31:0]            addr_issue_cnt,
  output logic [STALL_CNT_W-1:0] addr_cycle_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [31:0]            cur_addr_reg;
  logic [7:0]             remaining_reg;
  logic [STALL_CNT_W-1:0] stall_reg;
  logic [STALL_CNT_W-1:0] cycle_cnt_reg;
  logic [31:0]            issue_cnt_reg;
  logic                   underrun_reg;
  logic                   done_reg;

  logic start;
  logic pop_word;
  logic handshake;

  assign start     = (state_reg == IDLE) && active_program;
  assign pop_word  = (state_reg == FETCH) && active_program && !addr_fifo_empty;
  assign handshake = (state_reg == ISSUE) && vctr_addr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (active_program) state_next = FETCH;
      end
      FETCH: begin
        if (!active_program)      state_next = IDLE;
        else if (!addr_fifo_empty) state_next = (addr_fifo_dout == END_MARKER) ? DONE : ISSUE;
      end
      ISSUE: begin
        // Abort wins over a same-cycle handshake; valid must drop next cycle.
        if (!active_program)                      state_next = IDLE;
        else if (handshake && remaining_reg == 8'd0) state_next = FETCH;
      end
      DONE: begin
        if (!active_program) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_fifo_rd       = pop_word;
    vctr_addr_valid    = (state_reg == ISSUE);
    vctr_addr          = cur_addr_reg;
    prog_done          = done_reg;
    addr_fifo_underrun = underrun_reg;
    addr_issue_cnt     = issue_cnt_reg;
    addr_cycle_cnt     = cycle_cnt_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      stall_reg     <= '0;
      cycle_cnt_reg <= '0;
      issue_cnt_reg <= '0;
      underrun_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      if (start) begin
        issue_cnt_reg <= '0;
        underrun_reg  <= 1'b0;
        cycle_cnt_reg <= '0;
        stall_reg     <= '0;
        done_reg      <= 1'b0;
      end

      if (pop_word) begin
        if (addr_fifo_dout == END_MARKER) begin
          done_reg <= 1'b1;
        end else begin
          cur_addr_reg  <= addr_fifo_dout;
          remaining_reg <= send_consec_addr ? consec_count : 8'd0;
        end
      end

      // Empty before anything was issued is just a slow start, not an underrun.
      if (state_reg == FETCH && active_program && addr_fifo_empty && issue_cnt_reg != 32'd0)
        underrun_reg <= 1'b1;

      if (handshake) begin
        issue_cnt_reg <= issue_cnt_reg + 32'd1;
        cycle_cnt_reg <= stall_reg;
        stall_reg     <= '0;
        if (remaining_reg != 8'd0) begin
          cur_addr_reg  <= cur_addr_reg + 32'd1;
          remaining_reg <= remaining_reg - 8'd1;
        end
      end else if (state_reg == ISSUE && stall_reg != {STALL_CNT_W{1'b1}}) begin
        stall_reg <= stall_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addr_sequencer.sv
// Bench for addr_sequencer: FWFT FIFO model plus an expected-address
// scoreboard filled when FIFO words are loaded.
module tb_addr_sequencer;

  localparam logic [31:0] END_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active_program = 1'b0;
  logic        send_consec_addr = 1'b0;
  logic [7:0]  consec_count = 8'd0;
  logic [31:0] addr_fifo_dout = 32'd0;
  logic        addr_fifo_empty = 1'b1;
  logic        addr_fifo_rd;
  logic [31:0] vctr_addr;
  logic        vctr_addr_valid;
  logic        vctr_addr_ready = 1'b0;
  logic        prog_done;
  logic        addr_fifo_underrun;
  logic [31:0] addr_issue_cnt;
  logic [15:0] addr_cycle_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int cyc    = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];

  addr_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .active_program     (active_program),
    .send_consec_addr   (send_consec_addr),
    .consec_count       (consec_count),
    .addr_fifo_dout     (addr_fifo_dout),
    .addr_fifo_empty    (addr_fifo_empty),
    .addr_fifo_rd       (addr_fifo_rd),
    .vctr_addr          (vctr_addr),
    .vctr_addr_valid    (vctr_addr_valid),
    .vctr_addr_ready    (vctr_addr_ready),
    .prog_done          (prog_done),
    .addr_fifo_underrun (addr_fifo_underrun),
    .addr_issue_cnt     (addr_issue_cnt),
    .addr_cycle_cnt     (addr_cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic fifo_refresh();
    addr_fifo_empty = (fifo_q.size() == 0);
    addr_fifo_dout  = addr_fifo_empty ? 32'd0 : fifo_q[0];
  endtask

  // Push a FIFO word and its expected address run into the scoreboard.
  task automatic load(input logic [31:0] word, input logic en, input logic [7:0] cnt);
    logic [31:0] a;
    fifo_q.push_back(word);
    if (word != END_W) begin
      a = word;
      for (int i = 0; i <= (en ? int'(cnt) : 0); i++) begin
        exp_q.push_back(a);
        a = a + 32'd1;
      end
    end
    fifo_refresh();
  endtask

  // One clock: observe at negedge, pop model FIFO after posedge.
  task automatic step();
    logic pend;
    pend = 1'b0;
    @(negedge clk);
    if (vctr_addr_valid && vctr_addr_ready) begin
      got_q.push_back(vctr_addr);
      got_cyc.push_back(cyc);
    end
    if (addr_fifo_rd) begin
      rd_cnt++;
      pend = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend && fifo_q.size() > 0) fifo_q.delete(0);
    fifo_refresh();
  endtask

  task automatic new_program();
    active_program = 1'b0;
    step();
    step();
    fifo_q.delete();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    rd_cnt = 0;
    fifo_refresh();
  endtask

  task automatic run_until_done(input string name);
    int n;
    n = 0;
    while (!prog_done && n < 200) begin
      step();
      n++;
    end
    n_cmp++;
    if (!prog_done) begin
      n_fail++;
      $display("FAIL %s_timeout: prog_done=%0b after %0d cycles, required 1", name, prog_done, n);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if ({vctr_addr_valid, addr_fifo_rd, prog_done, addr_fifo_underrun} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000",
               {vctr_addr_valid, addr_fifo_rd, prog_done, addr_fifo_underrun});
    end
    n_cmp++;
    if (vctr_addr !== 32'd0 || addr_issue_cnt !== 32'd0 || addr_cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h issue=%0d cycle=%0d required all 0",
               vctr_addr, addr_issue_cnt, addr_cycle_cnt);
    end
    step();
    step();
    reset = 1'b1;
    step();
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    new_program();
    send_consec_addr = 1'b0;
    vctr_addr_ready  = 1'b1;
    load(32'h100, 1'b0, 8'd0);
    load(32'h200, 1'b0, 8'd0);
    load(END_W, 1'b0, 8'd0);
    active_program = 1'b1;
    run_until_done("basic");
    step();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count: got %0d addresses required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_addr[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_cyc.size() == 2) begin
      n_cmp++;
      if (got_cyc[1] - got_cyc[0] != 2) begin
        n_fail++;
        $display("FAIL basic_spacing: got %0d cycles required 2", got_cyc[1] - got_cyc[0]);
      end
    end
    n_cmp++;
    if (addr_issue_cnt !== 32'd2 || rd_cnt != 3 || addr_fifo_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: issue=%0d rd=%0d underrun=%0b required 2 3 0",
               addr_issue_cnt, rd_cnt, addr_fifo_underrun);
    end
    active_program = 1'b0;
    step();
    step();
    n_cmp++;
    if (prog_done !== 1'b1 || addr_issue_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL basic_hold_idle: done=%0b issue=%0d required 1 2", prog_done, addr_issue_cnt);
    end
    $display("basic: %0d addresses, %0d pops, issue_cnt=%0d", got_q.size(), rd_cnt, addr_issue_cnt);
  endtask

  task automatic test_expansion();
    int n;
    new_program();
    send_consec_addr = 1'b1;
    consec_count     = 8'd3;
    vctr_addr_ready  = 1'b1;
    load(32'h1000, 1'b1, 8'd3);
    load(END_W, 1'b1, 8'd3);
    active_program = 1'b1;
    n = 0;
    while (got_q.size() < 1 && n < 50) begin
      step();
      n++;
    end
    consec_count     = 8'd0;
    send_consec_addr = 1'b0;
    run_until_done("expansion");
    step();
    n_cmp++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL expansion_count: got %0d addresses required 4", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL expansion_addr[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      n_cmp++;
      if (got_cyc[i] - got_cyc[i-1] != 1) begin
        n_fail++;
        $display("FAIL expansion_b2b[%0d]: gap %0d cycles required 1", i, got_cyc[i] - got_cyc[i-1]);
      end
    end
    n_cmp++;
    if (addr_issue_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL expansion_issue_cnt: got %0d required 4", addr_issue_cnt);
    end
    $display("expansion: %0d addresses from one word, issue_cnt=%0d", got_q.size(), addr_issue_cnt);
  endtask

  task automatic test_wrap_stall();
    int n;
    new_program();
    send_consec_addr = 1'b1;
    consec_count     = 8'd2;
    vctr_addr_ready  = 1'b0;
    load(32'hFFFF_FFFE, 1'b1, 8'd2);
    load(END_W, 1'b1, 8'd2);
    active_program = 1'b1;
    n = 0;
    while (!vctr_addr_valid && n < 50) begin
      step();
      n++;
    end
    repeat (5) step();
    vctr_addr_ready = 1'b1;
    step();
    n_cmp++;
    if (addr_cycle_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL wrap_stall_cnt: got %0d required 5", addr_cycle_cnt);
    end
    step();
    step();
    n_cmp++;
    if (addr_cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_stall_clear: got %0d required 0", addr_cycle_cnt);
    end
    run_until_done("wrap");
    n_cmp++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d addresses required 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    $display("wrap_stall: %0d addresses, last stall=%0d", got_q.size(), addr_cycle_cnt);
  endtask

  task automatic test_underrun();
    int n;
    new_program();
    send_consec_addr = 1'b0;
    vctr_addr_ready  = 1'b1;
    active_program   = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (addr_fifo_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_early: got %0b required 0", addr_fifo_underrun);
    end
    load(32'h40, 1'b0, 8'd0);
    n = 0;
    while (got_q.size() < 1 && n < 50) begin
      step();
      n++;
    end
    repeat (5) step();
    n_cmp++;
    if (addr_fifo_underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_set: got %0b required 1", addr_fifo_underrun);
    end
    load(END_W, 1'b0, 8'd0);
    run_until_done("underrun");
    n_cmp++;
    if (addr_fifo_underrun !== 1'b1 || addr_issue_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL underrun_sticky: underrun=%0b issue=%0d required 1 1",
               addr_fifo_underrun, addr_issue_cnt);
    end
    if (got_q.size() > 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL underrun_addr: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    active_program = 1'b0;
    step();
    step();
    n_cmp++;
    if (addr_fifo_underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_hold_idle: got %0b required 1", addr_fifo_underrun);
    end
    active_program = 1'b1;
    step();
    n_cmp++;
    if (addr_fifo_underrun !== 1'b0 || prog_done !== 1'b0 || addr_issue_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL underrun_restart: underrun=%0b done=%0b issue=%0d required 0 0 0",
               addr_fifo_underrun, prog_done, addr_issue_cnt);
    end
    $display("underrun: flag set after issue, cleared on restart");
  endtask

  task automatic test_abort();
    int n;
    int rd_snap;
    new_program();
    send_consec_addr = 1'b0;
    vctr_addr_ready  = 1'b1;
    load(32'h80, 1'b0, 8'd0);
    load(32'h90, 1'b0, 8'd0);
    load(END_W, 1'b0, 8'd0);
    active_program = 1'b1;
    n = 0;
    while (got_q.size() < 1 && n < 50) begin
      step();
      n++;
    end
    vctr_addr_ready = 1'b0;
    n = 0;
    while (!vctr_addr_valid && n < 50) begin
      step();
      n++;
    end
    repeat (3) step();
    rd_snap = rd_cnt;
    active_program = 1'b0;
    step();
    n_cmp++;
    if (vctr_addr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_valid: got %0b required 0", vctr_addr_valid);
    end
    repeat (3) step();
    n_cmp++;
    if (rd_cnt != rd_snap || rd_cnt != 2) begin
      n_fail++;
      $display("FAIL abort_rd: got %0d pops required 2", rd_cnt);
    end
    n_cmp++;
    if (addr_issue_cnt !== 32'd1 || addr_cycle_cnt !== 16'd0 || vctr_addr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_retain: issue=%0d cycle=%0d valid=%0b required 1 0 0",
               addr_issue_cnt, addr_cycle_cnt, vctr_addr_valid);
    end
    if (got_q.size() > 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL abort_addr: got %h required %h", got_q[0], exp_q[0]);
      end
    end
    active_program = 1'b1;
    step();
    n_cmp++;
    if (addr_issue_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_restart_clear: issue=%0d required 0", addr_issue_cnt);
    end
    run_until_done("abort_restart");
    $display("abort: valid dropped, %0d pops, restart cleared counters", rd_cnt);
  endtask

  task automatic test_async_reset();
    int n;
    new_program();
    send_consec_addr = 1'b0;
    vctr_addr_ready  = 1'b1;
    load(32'h500, 1'b0, 8'd0);
    load(32'h600, 1'b0, 8'd0);
    load(END_W, 1'b0, 8'd0);
    active_program = 1'b1;
    n = 0;
    while (got_q.size() < 1 && n < 50) begin
      step();
      n++;
    end
    vctr_addr_ready = 1'b0;
    n = 0;
    while (!vctr_addr_valid && n < 50) begin
      step();
      n++;
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({vctr_addr_valid, addr_fifo_rd, prog_done, addr_fifo_underrun} !== 4'b0) begin
      n_fail++;
      $display("FAIL async_reset_flags: got %b required 0000",
               {vctr_addr_valid, addr_fifo_rd, prog_done, addr_fifo_underrun});
    end
    n_cmp++;
    if (vctr_addr !== 32'd0 || addr_issue_cnt !== 32'd0 || addr_cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset_values: addr=%h issue=%0d cycle=%0d required all 0",
               vctr_addr, addr_issue_cnt, addr_cycle_cnt);
    end
    active_program = 1'b0;
    step();
    reset = 1'b1;
    step();
    $display("async_reset: outputs cleared between clock edges");
  endtask

  initial begin
    fifo_refresh();
    test_reset();
    test_basic();
    test_expansion();
    test_wrap_stall();
    test_underrun();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Sits directly downstream of the address FIFO that driver_cntrl loads through register 0x0.
- Pops 32-bit address words from that FIFO (first-word-fall-through) and optionally expands each word into a run of consecutive addresses.
- Issues the addresses over a valid/ready handshake to the vector fetch stage.
- Reports underrun, issue count and per-address stall cycles back to the control/status register block.

Parameters:
- END_MARKER, 32'hFFFF_FFFF, FIFO word value that terminates the program.
- STALL_CNT_W, 16, width of the per-address stall counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- active_program  in  1  level from control block; high = program running.
- send_consec_addr  in  1  control word bit 7; enables consecutive expansion.
- consec_count  in  8  control word bits 15:8; extra addresses per FIFO word.
- addr_fifo_dout  in  32  FWFT FIFO head word.
- addr_fifo_empty  in  1  FIFO empty.
- addr_fifo_rd  out  1  pop strobe, one cycle per word.
- vctr_addr  out  32  address to vector fetch stage.
- vctr_addr_valid  out  1  vctr_addr valid.
- vctr_addr_ready  in  1  downstream accepts.
- prog_done  out  1  level; END_MARKER consumed.
- addr_fifo_underrun  out  1  sticky underrun flag.
- addr_issue_cnt  out  32  handshakes completed this program.
- addr_cycle_cnt  out  16  stall cycles of the last accepted address.

Behaviour:
- Reset (async, reset==0): state IDLE; all outputs 0; internal cur_addr, remaining and stall counter 0.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - addr_fifo_rd=0, valid=0.
  - When active_program==1: go to FETCH; clear addr_issue_cnt, addr_fifo_underrun, addr_cycle_cnt and prog_done.
- FETCH:
  - If !addr_fifo_empty: addr_fifo_rd=1 for exactly this cycle.
  - Head == END_MARKER: go to DONE.
  - Any other head: cur_addr<=head; remaining<=send_consec_addr ? consec_count : 0, with both controls sampled in this cycle; go to ISSUE.
  - If empty: stay in FETCH; set addr_fifo_underrun if addr_issue_cnt!=0. An empty FIFO before the first issue is not an underrun.
- ISSUE:
  - vctr_addr=cur_addr, vctr_addr_valid=1. Both are registered and stable until handshake.
  - Handshake = valid && ready. On handshake: addr_issue_cnt+=1; addr_cycle_cnt<=stall counter; stall counter<=0.
  - After handshake with remaining==0: go to FETCH.
  - After handshake otherwise: cur_addr<=cur_addr+1 (mod 2^32, 0xFFFF_FFFF wraps to 0); remaining-=1; stay in ISSUE with valid held high (back-to-back, one address per cycle).
  - Valid && !ready: stall counter+=1, saturating at 2^STALL_CNT_W-1.
- DONE: prog_done=1, valid=0, no pops; stay until active_program==0.
- Abort: active_program==0 in FETCH, ISSUE or DONE means next state IDLE. valid drops the next cycle even mid-handshake, with no pop in that cycle. prog_done, addr_issue_cnt, addr_fifo_underrun and addr_cycle_cnt hold their values in IDLE so software can read them after end/abort.
- Latency: FIFO word present in FETCH → valid asserted on the next cycle. Steady-state throughput with send_consec_addr=0 is 1 address per 2 cycles.
- Expansion count: each FIFO word yields consec_count+1 addresses when send_consec_addr=1; consec_count=0 yields 1 address. Changes to consec_count or send_consec_addr during ISSUE do not affect the word in flight.
- addr_issue_cnt wraps at 2^32. addr_fifo_underrun only clears on IDLE→FETCH.
- Reset asserted mid-operation: immediate return to reset values; the FIFO itself is not touched.

Test Plan:
- Basic run: FIFO={0x100,0x200,END}, send_consec_addr=0, ready=1, active=1 → addresses 0x100, 0x200 issued; prog_done=1; addr_issue_cnt=2; exactly 3 rd pulses; underrun=0.
- Expansion: FIFO={0x1000,END}, send_consec_addr=1, consec_count=3, ready=1 → 0x1000..0x1003 issued on 4 consecutive cycles; addr_issue_cnt=4. Toggling consec_count mid-burst has no effect.
- Wrap and stall: FIFO={0xFFFF_FFFE,END}, consec=2, ready low 5 cycles on the first address → sequence 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. addr_cycle_cnt reads 5, then 0 after the next two addresses.
- Underrun: start with empty FIFO for 10 cycles → underrun=0. Push 0x40; after its handshake leave FIFO empty → underrun=1 and it stays 1 after a later push. It clears only on the next program start.
- Abort: deassert active_program while valid=1 and ready=0 → valid=0 next cycle; state IDLE; no extra rd; counters retained. Re-assert → counters cleared.
- Async reset: pull reset low mid-ISSUE between clock edges → all outputs 0 immediately, without waiting for a clock edge.
